multi_channel_mem_controller: RTL and testbench

- Arbitrates N consumer load/store ports (LSUs or instruction fetchers) onto C parallel external-memory channels.
- Each channel independently claims one pending consumer request, forwards it to memory, waits for the memory ready, then relays ready and data back to the consumer.
- Instantiated twice in the GPU top level:
  - data memory: read/write;
  - instruction memory: read-only, with WRITE_ENABLE=0.

---
 rtl/multi_channel_mem_controller_pkg.sv | 25 ++
 rtl/multi_channel_mem_controller_channel.sv | 96 +++++++++
 rtl/multi_channel_mem_controller.sv | 131 +++++++++++++
 tb/tb_multi_channel_mem_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// multi_channel_mem_controller_pkg - shared types and widths. Rev 1.0
// ============================================================================
package multi_channel_mem_controller_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int INSTRUCTION_WIDTH     = 16;
  localparam int DATA_ADDRESS_WIDTH    = 32;
  localparam int PROGRAM_ADDRESS_WIDTH = 32;

  typedef logic [DEFAULT_DATA_WIDTH-1:0]    data_t;
  typedef logic [DATA_ADDRESS_WIDTH-1:0]    data_address_t;
  typedef logic [PROGRAM_ADDRESS_WIDTH-1:0] program_address_t;

  typedef enum logic [2:0] {
    CH_IDLE           = 3'd0,
    CH_READ_WAITING   = 3'd1,
    CH_WRITE_WAITING  = 3'd2,
    CH_READ_RELAYING  = 3'd3,
    CH_WRITE_RELAYING = 3'd4
  } channel_state_t;

endpackage
`default_nettype wire

// File: rtl/multi_channel_mem_controller_channel.sv
`default_nettype none
// ============================================================================
// mem_channel_fsm - one memory channel: issue, wait for memory, relay ready. Rev 1.0
// ============================================================================
module mem_channel_fsm
  import multi_channel_mem_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DATA_ADDRESS_WIDTH,
  parameter int ID_WIDTH      = 5,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grant,
  input  logic                     grant_write,
  input  logic [ID_WIDTH-1:0]      grant_id,
  input  logic [ADDRESS_WIDTH-1:0] grant_address,
  input  logic [DATA_WIDTH-1:0]    grant_data,
  input  logic                     mem_read_ready,
  input  logic                     mem_write_ready,
  input  logic                     owner_read_valid,
  input  logic                     owner_write_valid,
  output channel_state_t           state,
  output logic [ID_WIDTH-1:0]      owner_id,
  output logic                     mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  output logic                     mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     read_done,
  output logic                     write_done,
  output logic                     release_claim
);

  channel_state_t state_next;
  logic           is_write;
  logic           take_read;
  logic           take_write;

  assign is_write = grant_write && (WRITE_ENABLE != 0);

  always_ff @(posedge clk) begin
    if (!reset) state <= CH_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CH_IDLE:           if (grant) state_next = is_write ? CH_WRITE_WAITING : CH_READ_WAITING;
      CH_READ_WAITING:   if (mem_read_ready) state_next = CH_READ_RELAYING;
      CH_WRITE_WAITING:  if (mem_write_ready) state_next = CH_WRITE_RELAYING;
      CH_READ_RELAYING:  if (!owner_read_valid) state_next = CH_IDLE;
      CH_WRITE_RELAYING: if (!owner_write_valid) state_next = CH_IDLE;
      default:           state_next = CH_IDLE;
    endcase
  end

  always_comb begin
    take_read     = (state == CH_IDLE) && grant && !is_write;
    take_write    = (state == CH_IDLE) && grant && is_write;
    read_done     = (state == CH_READ_WAITING) && mem_read_ready;
    write_done    = (state == CH_WRITE_WAITING) && mem_write_ready;
    release_claim = ((state == CH_READ_RELAYING) && !owner_read_valid) ||
                    ((state == CH_WRITE_RELAYING) && !owner_write_valid);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_id          <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
    end else begin
      if (take_read || take_write) owner_id <= grant_id;
      if (take_read) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= grant_address;
      end else if (read_done) begin
        mem_read_valid <= 1'b0;
      end
      if (take_write) begin
        mem_write_valid   <= 1'b1;
        mem_write_address <= grant_address;
        mem_write_data    <= grant_data;
      end else if (write_done) begin
        mem_write_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_channel_mem_controller.sv
`default_nettype none
// ============================================================================
// multi_channel_mem_controller - arbitrates consumer ports onto memory channels. Rev 1.0
// ============================================================================
module multi_channel_mem_controller
  import multi_channel_mem_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DATA_ADDRESS_WIDTH,
  parameter int NUM_CONSUMERS = 17,
  parameter int NUM_CHANNELS  = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDRESS_WIDTH-1:0] consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_WIDTH-1:0]    consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDRESS_WIDTH-1:0] consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_WIDTH-1:0]    consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]  mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
  input  logic [DATA_WIDTH-1:0]    mem_read_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]  mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address [NUM_CHANNELS],
  output logic [DATA_WIDTH-1:0]    mem_write_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

  localparam int ID_WIDTH = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [NUM_CONSUMERS-1:0] claim;
  logic [NUM_CONSUMERS-1:0] claim_next;
  logic [NUM_CONSUMERS-1:0] mask;
  logic [NUM_CONSUMERS-1:0] release_mask;
  channel_state_t           ch_state [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]      ch_id    [NUM_CHANNELS];
  logic [ID_WIDTH-1:0]      grant_id [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CHANNELS-1:0]  grant_write;
  logic [NUM_CHANNELS-1:0]  read_done;
  logic [NUM_CHANNELS-1:0]  write_done;
  logic [NUM_CHANNELS-1:0]  release_claim;

  // Channels scan in index order; each grant is folded into the mask before the next channel looks.
  always_comb begin
    mask         = claim;
    grant        = '0;
    grant_write  = '0;
    release_mask = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_id[ch] = '0;
      if (ch_state[ch] == CH_IDLE) begin
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
          if (!grant[ch] && !mask[c] &&
              (consumer_read_valid[c] || ((WRITE_ENABLE != 0) && consumer_write_valid[c]))) begin
            grant[ch]       = 1'b1;
            grant_write[ch] = !consumer_read_valid[c];
            grant_id[ch]    = ID_WIDTH'(c);
            mask[c]         = 1'b1;
          end
        end
      end
      if (release_claim[ch]) release_mask[ch_id[ch]] = 1'b1;
    end
    claim_next = mask & ~release_mask;
  end

  generate
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
      mem_channel_fsm #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .ID_WIDTH      (ID_WIDTH),
        .WRITE_ENABLE  (WRITE_ENABLE)
      ) u_fsm (
        .clk               (clk),
        .reset             (reset),
        .grant             (grant[ch]),
        .grant_write       (grant_write[ch]),
        .grant_id          (grant_id[ch]),
        .grant_address     (grant_write[ch] ? consumer_write_address[grant_id[ch]]
                                            : consumer_read_address[grant_id[ch]]),
        .grant_data        (consumer_write_data[grant_id[ch]]),
        .mem_read_ready    (mem_read_ready[ch]),
        .mem_write_ready   (mem_write_ready[ch]),
        .owner_read_valid  (consumer_read_valid[ch_id[ch]]),
        .owner_write_valid (consumer_write_valid[ch_id[ch]]),
        .state             (ch_state[ch]),
        .owner_id          (ch_id[ch]),
        .mem_read_valid    (mem_read_valid[ch]),
        .mem_read_address  (mem_read_address[ch]),
        .mem_write_valid   (mem_write_valid[ch]),
        .mem_write_address (mem_write_address[ch]),
        .mem_write_data    (mem_write_data[ch]),
        .read_done         (read_done[ch]),
        .write_done        (write_done[ch]),
        .release_claim     (release_claim[ch])
      );
    end
  endgenerate

  // Channel ids are distinct, so per-channel updates never collide on one consumer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      claim                <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int c = 0; c < NUM_CONSUMERS; c++) consumer_read_data[c] <= '0;
    end else begin
      claim <= claim_next;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (read_done[ch]) begin
          consumer_read_ready[ch_id[ch]] <= 1'b1;
          consumer_read_data[ch_id[ch]]  <= mem_read_data[ch];
        end
        if (write_done[ch]) consumer_write_ready[ch_id[ch]] <= 1'b1;
        if (release_claim[ch]) begin
          consumer_read_ready[ch_id[ch]]  <= 1'b0;
          consumer_write_ready[ch_id[ch]] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_mem_controller.sv
`default_nettype none
// ============================================================================
// tb_multi_channel_mem_controller - directed bench, read/write and read-only instances. Rev 1.0
// ============================================================================
module tb_multi_channel_mem_controller;

  localparam int NC  = 17;
  localparam int NCH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] crv, cwv;
  logic [31:0]   cra [NC];
  logic [31:0]   cwa [NC];
  logic [31:0]   cwd [NC];
  logic [NCH-1:0] mrr, mwr;
  logic [31:0]   mrd [NCH];

  logic [NC-1:0]  crr, cwr, crr_ro, cwr_ro;
  logic [31:0]    crd [NC];
  logic [31:0]    crd_ro [NC];
  logic [NCH-1:0] mrv, mwv, mrv_ro, mwv_ro;
  logic [31:0]    mra [NCH];
  logic [31:0]    mwa [NCH];
  logic [31:0]    mwd [NCH];
  logic [31:0]    mra_ro [NCH];
  logic [31:0]    mwa_ro [NCH];
  logic [31:0]    mwd_ro [NCH];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_channel_mem_controller #(
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  multi_channel_mem_controller #(
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH), .WRITE_ENABLE(0)
  ) dut_ro (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr_ro), .consumer_read_data(crd_ro),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr_ro),
    .mem_read_valid(mrv_ro), .mem_read_address(mra_ro),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv_ro), .mem_write_address(mwa_ro),
    .mem_write_data(mwd_ro), .mem_write_ready(mwr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    crv = '0; cwv = '0; mrr = '0; mwr = '0;
    for (int i = 0; i < NC; i++) begin cra[i] = '0; cwa[i] = '0; cwd[i] = '0; end
    for (int i = 0; i < NCH; i++) mrd[i] = '0;
    tick(); tick();
    check("reset_mrv", 64'(mrv), 64'h0);
    check("reset_mwv", 64'(mwv), 64'h0);
    check("reset_crr", 64'(crr), 64'h0);
    check("reset_cwr", 64'(cwr), 64'h0);
    reset = 1'b1;
    tick();

    // Single read, consumer 3
    crv[3] = 1'b1; cra[3] = 32'h40;
    tick();
    check("rd_mrv", 64'(mrv), 64'h1);
    check("rd_mra", 64'(mra[0]), 64'h40);
    mrr[0] = 1'b1; mrd[0] = 32'hDEADBEEF;
    tick();
    check("rd_crr", 64'(crr), 64'h8);
    check("rd_crd", 64'(crd[3]), 64'hDEADBEEF);
    check("rd_mrv_clr", 64'(mrv), 64'h0);
    mrr[0] = 1'b0; crv[3] = 1'b0;
    tick();
    check("rd_crr_drop", 64'(crr), 64'h0);
    check("rd_crd_hold", 64'(crd[3]), 64'hDEADBEEF);
    tick();

    // Parallel claims: consumers 0,1,2 on two channels
    crv[2:0] = 3'b111; cra[0] = 32'h100; cra[1] = 32'h104; cra[2] = 32'h108;
    tick();
    check("par_mrv", 64'(mrv), 64'h3);
    check("par_mra0", 64'(mra[0]), 64'h100);
    check("par_mra1", 64'(mra[1]), 64'h104);
    mrr = 2'b11; mrd[0] = 32'hA0; mrd[1] = 32'hA1;
    tick();
    check("par_crr", 64'(crr), 64'h3);
    check("par_crd0", 64'(crd[0]), 64'hA0);
    check("par_crd1", 64'(crd[1]), 64'hA1);
    mrr = 2'b00; crv[0] = 1'b0;
    tick();
    check("par_rel0", 64'(crr), 64'h2);
    tick();
    check("par_c2_mrv", 64'(mrv), 64'h1);
    check("par_c2_mra", 64'(mra[0]), 64'h108);
    mrr[0] = 1'b1; mrd[0] = 32'hA2;
    tick();
    check("par_c2_crr", 64'(crr), 64'h6);
    check("par_c2_crd", 64'(crd[2]), 64'hA2);
    mrr = '0; crv = '0;
    tick();
    check("par_done", 64'(crr), 64'h0);
    tick();

    // Ready hold with memory ready left high: no re-issue
    crv[7] = 1'b1; cra[7] = 32'h70;
    tick();
    mrr[0] = 1'b1; mrd[0] = 32'h77;
    tick();
    check("hold_crr", 64'(crr), 64'h80);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_crr_k", 64'(crr), 64'h80);
      check("hold_mrv_k", 64'(mrv), 64'h0);
    end
    mrr = '0; crv[7] = 1'b0;
    tick();
    check("hold_drop", 64'(crr), 64'h0);
    tick();

    // Write, consumer 5; read-only instance must ignore it
    cwv[5] = 1'b1; cwa[5] = 32'h80; cwd[5] = 32'h1234;
    tick();
    check("wr_mwv", 64'(mwv), 64'h1);
    check("wr_mwa", 64'(mwa[0]), 64'h80);
    check("wr_mwd", 64'(mwd[0]), 64'h1234);
    check("wr_mrv", 64'(mrv), 64'h0);
    check("ro_mwv", 64'(mwv_ro), 64'h0);
    mwr[0] = 1'b1;
    tick();
    check("wr_cwr", 64'(cwr), 64'h20);
    check("wr_mwv_clr", 64'(mwv), 64'h0);
    check("ro_cwr", 64'(cwr_ro), 64'h0);
    check("ro_mwv2", 64'(mwv_ro), 64'h0);
    mwr = '0; cwv[5] = 1'b0;
    tick();
    check("wr_drop", 64'(cwr), 64'h0);
    tick();

    // Read takes priority over write for the same consumer
    crv[6] = 1'b1; cwv[6] = 1'b1; cra[6] = 32'h60; cwa[6] = 32'h61;
    tick();
    check("prio_mrv", 64'(mrv), 64'h1);
    check("prio_mwv", 64'(mwv), 64'h0);
    check("prio_mra", 64'(mra[0]), 64'h60);
    mrr[0] = 1'b1; mrd[0] = 32'h66;
    tick();
    check("prio_crr", 64'(crr), 64'h40);
    mrr = '0; crv = '0; cwv = '0;
    tick(); tick();

    // Reset while in READ_WAITING, then reuse
    crv[4] = 1'b1; cra[4] = 32'h44;
    tick();
    check("rst_mrv_pre", 64'(mrv), 64'h1);
    reset = 1'b0;
    tick();
    check("rst_mrv", 64'(mrv), 64'h0);
    check("rst_crr", 64'(crr), 64'h0);
    reset = 1'b1;
    tick();
    check("rst_reuse_mrv", 64'(mrv), 64'h1);
    check("rst_reuse_mra", 64'(mra[0]), 64'h44);
    mrr[0] = 1'b1; mrd[0] = 32'h55;
    tick();
    check("rst_reuse_crr", 64'(crr), 64'h10);
    check("rst_reuse_crd", 64'(crd[4]), 64'h55);
    mrr = '0; crv = '0;
    tick();
    check("final_idle", 64'(crr), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
